fp_round_pack: RTL and testbench
================================

// Module: fp_round_pack
// PURPOSE
//  Final stage of the FP multiply/divide datapath: takes the aligned result sign, the
//  pre-normalisation biased exponent and the wide significand, then normalises, rounds
//  (round-to-nearest-even), detects overflow/underflow and packs an IEEE-754 word.
//  Fed by the sign delay line and the exponent/significand pipelines, all same-cycle aligned.
//  2-stage pipeline, stalled by the shared enable.
// PARAMETERS
//  EXP_W  8   exponent field width (bias = 2**(EXP_W-1)-1)
//  MAN_W  23  stored fraction width; significand input is 2*(MAN_W+1) bits
// PORTS
//  clk        in   1            rising-edge clock
//  arst       in   1            asynchronous reset, active-high
//  en         in   1            pipeline advance; low = every register holds
//  valid_in   in   1            inputs carry a result this cycle
//  s_in       in   1            result sign (already XORed and aligned)
//  exp_in     in   EXP_W+2      signed two's-complement biased exponent, before normalisation
//  mant_in    in   2*MAN_W+2    significand, fixed point 2.(2*MAN_W), value in [1,4)
//  nan_in     in   1            special: result is NaN
//  inf_in     in   1            special: result is infinity
//  zero_in    in   1            special: result is zero
//  result     out  EXP_W+MAN_W+1  packed {sign, exponent, fraction}
//  valid_out  out  1            result valid
//  overflow   out  1            result saturated to infinity
//  underflow  out  1            result flushed to zero
//  inexact    out  1            result differs from exact value
// BEHAVIOUR
//  Reset: all pipeline registers and all outputs 0, asynchronously, from any state.
//  Latency: exactly 2 en-qualified clock edges; valid_out = valid_in delayed 2 en-edges.
//  en low: no register changes (payload or valid). Payload registers load on every en edge,
//   valid or not; result/flags are meaningful only when valid_out=1.
//  Stage 1 (normalise): if mant_in[MSB]=1, shift right 1 and exp+1; else unchanged.
//   Keep MAN_W+1 significand bits, guard bit G, sticky S = OR of all lower bits (including
//   the bit shifted out). Register sign, exp (EXP_W+2 signed), significand, G, S, specials, valid.
//  Stage 2 (round/pack): round_up = G & (S | lsb). Add round_up to the significand; on carry-out
//   significand = 1.000..0 and exp+1. inexact = G|S.
//   Final exp >= 2**EXP_W-1: result = {s, all-ones, 0}; overflow=1, inexact=1.
//   Final exp <= 0: result = {s, 0, 0} (no subnormals, flush-to-zero); underflow=1, inexact=1.
//   Otherwise: result = {s, exp[EXP_W-1:0], fraction without hidden bit}; overflow=underflow=0.
//  Specials override the arithmetic path; priority nan_in > inf_in > zero_in:
//   NaN -> canonical qNaN {0, all-ones, 1, 0..0} (0x7FC00000); inf -> {s, all-ones, 0};
//   zero -> {s, 0, 0}; all three flags 0 for any special.
//  Overflow/underflow are evaluated on the post-rounding exponent (carry-out can overflow).
//  Flags are registered alongside result and always correspond to the same word.
// TESTING (defaults EXP_W=8, MAN_W=23; en=1 unless stated)
//  1.5*1.5: s=0, exp_in=127, mant_in=0x900000000000 -> 2 cycles later result=0x40100000,
//   all flags 0.
//  RNE ties: exp_in=127, mant_in=0x400000400000 -> 0x3F800000, inexact=1;
//   mant_in=0x400000C00000 -> 0x3F800002, inexact=1.
//  Rounding carry: exp_in=127, mant_in=0x7FFFFFC00000 -> 0x40000000, inexact=1.
//  Overflow: exp_in=254, mant_in=0x800000000000, s=0 -> 0x7F800000, overflow=1, inexact=1.
//   Underflow: exp_in=0, mant_in=0x400000000000, s=1 -> 0x80000000, underflow=1, inexact=1.
//  Specials/priority: nan_in=inf_in=1 -> 0x7FC00000; inf_in=1, s=1 -> 0xFF800000; flags 0.
//  Stall and reset: back-to-back valids with en low 3 cycles mid-flight -> outputs frozen, order
//   and values preserved; arst pulsed with valids in flight -> outputs 0 immediately, no stale
//   valid_out after release.

Source files
------------

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalise, round-to-nearest-even and pack an IEEE-754 word.
// Stage 1 normalises the [1,4) significand and extracts guard/sticky bits;
// stage 2 rounds, checks exponent range, applies specials and registers the packed word.
module fp_round_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     en,
    input  logic                     valid_in,
    input  logic                     s_in,
    input  logic signed [EXP_W+1:0]  exp_in,
    input  logic [2*MAN_W+1:0]       mant_in,
    input  logic                     nan_in,
    input  logic                     inf_in,
    input  logic                     zero_in,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     valid_out,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     inexact
);

    localparam int SIG_W = 2*MAN_W + 2;
    localparam logic signed [EXP_W+2:0] EXP_MAX = {3'b000, {EXP_W{1'b1}}};

    // Stage-1 registers. The hidden bit is always 1 after normalisation, so only the fraction is kept.
    logic                    r_sign;
    logic signed [EXP_W+1:0] r_exp;
    logic [MAN_W-1:0]        r_frac;
    logic                    r_g;
    logic                    r_s;
    logic                    r_nan;
    logic                    r_inf;
    logic                    r_zero;
    logic                    r_valid;

    logic signed [EXP_W+1:0] w_exp;
    logic [MAN_W-1:0]        w_frac;
    logic                    w_g;
    logic                    w_s;

    // Normalise: values in [2,4) shift right one place and bump the exponent.
    always_comb begin
        w_exp  = exp_in;
        w_frac = mant_in[SIG_W-3 -: MAN_W];
        w_g    = mant_in[MAN_W-1];
        w_s    = |mant_in[MAN_W-2:0];
        if (mant_in[SIG_W-1]) begin
            w_exp  = exp_in + {{(EXP_W+1){1'b0}}, 1'b1};
            w_frac = mant_in[SIG_W-2 -: MAN_W];
            w_g    = mant_in[MAN_W];
            w_s    = |mant_in[MAN_W-1:0];
        end
    end

    // Stage-1 pipeline register; payload loads on every enabled edge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_frac  <= '0;
            r_g     <= 1'b0;
            r_s     <= 1'b0;
            r_nan   <= 1'b0;
            r_inf   <= 1'b0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_sign  <= s_in;
            r_exp   <= w_exp;
            r_frac  <= w_frac;
            r_g     <= w_g;
            r_s     <= w_s;
            r_nan   <= nan_in;
            r_inf   <= inf_in;
            r_zero  <= zero_in;
            r_valid <= valid_in;
        end
    end

    logic                    w_round_up;
    logic                    w_carry;
    logic [MAN_W-1:0]        w_frac_rnd;
    logic signed [EXP_W+2:0] w_exp_fin;
    logic                    w_ovf_rng;
    logic                    w_unf_rng;
    logic [EXP_W+MAN_W:0]    w_res;
    logic                    w_ovf;
    logic                    w_unf;
    logic                    w_inx;

    // Round to nearest even. A carry out of an all-ones fraction wraps it to zero,
    // which is exactly the 1.000..0 significand, so only the exponent needs the carry.
    always_comb begin
        w_round_up = r_g & (r_s | r_frac[0]);
        w_carry    = w_round_up & (&r_frac);
        w_frac_rnd = r_frac + {{(MAN_W-1){1'b0}}, w_round_up};
        w_exp_fin  = {r_exp[EXP_W+1], r_exp} + {{(EXP_W+2){1'b0}}, w_carry};
        w_ovf_rng  = (w_exp_fin >= EXP_MAX);
        w_unf_rng  = w_exp_fin[EXP_W+2] | (w_exp_fin == '0);
    end

    // Pack: specials first (nan > inf > zero), then range checks on the rounded exponent.
    always_comb begin
        w_res = {r_sign, w_exp_fin[EXP_W-1:0], w_frac_rnd};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_inx = r_g | r_s;
        if (r_nan) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_inx = 1'b0;
        end else if (r_inf) begin
            w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_inx = 1'b0;
        end else if (r_zero) begin
            w_res = {r_sign, {(EXP_W+MAN_W){1'b0}}};
            w_inx = 1'b0;
        end else if (w_ovf_rng) begin
            w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end else if (w_unf_rng) begin
            w_res = {r_sign, {(EXP_W+MAN_W){1'b0}}};
            w_unf = 1'b1;
            w_inx = 1'b1;
        end
    end

    // Output register: word and flags always move together.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            result    <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else if (en) begin
            result    <= w_res;
            valid_out <= r_valid;
            overflow  <= w_ovf;
            underflow <= w_unf;
            inexact   <= w_inx;
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed vector table, stall/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_fp_round_pack;

    logic               clk = 1'b0;
    logic               arst = 1'b1;
    logic               en = 1'b1;
    logic               valid_in = 1'b0;
    logic               s_in = 1'b0;
    logic signed [9:0]  exp_in = '0;
    logic [47:0]        mant_in = '0;
    logic               nan_in = 1'b0;
    logic               inf_in = 1'b0;
    logic               zero_in = 1'b0;
    logic [31:0]        result;
    logic               valid_out;
    logic               overflow;
    logic               underflow;
    logic               inexact;

    int checks = 0;
    int errors = 0;

    fp_round_pack #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .arst(arst), .en(en), .valid_in(valid_in), .s_in(s_in),
        .exp_in(exp_in), .mant_in(mant_in), .nan_in(nan_in), .inf_in(inf_in),
        .zero_in(zero_in), .result(result), .valid_out(valid_out),
        .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        int          e;
        logic [47:0] m;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [31:0] res;
        logic [2:0]  fl;   // {overflow, underflow, inexact}
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic s, input int e, input logic [47:0] m,
                          input logic nan, input logic inf, input logic zero);
        valid_in = v;
        s_in     = s;
        exp_in   = e[9:0];
        mant_in  = m;
        nan_in   = nan;
        inf_in   = inf;
        zero_in  = zero;
    endtask

    // Reference: value = m / 2^46 * 2^(e-127); rounding by remainder vs. half-ulp.
    function automatic exp_t model(input logic s, input int e, input logic [47:0] m,
                                   input logic nan, input logic inf, input logic zero);
        exp_t   r;
        longint mv, q, rem, half;
        int     sh, ee;
        r.fl = 3'b000;
        if (nan) begin
            r.res = 32'h7FC0_0000;
        end else if (inf) begin
            r.res = {s, 8'hFF, 23'h0};
        end else if (zero) begin
            r.res = {s, 31'h0};
        end else begin
            mv = longint'(m);
            ee = e;
            if (mv >= (64'sd1 <<< 47)) begin
                ee = ee + 1;
                sh = 24;
            end else begin
                sh = 23;
            end
            q    = mv >>> sh;
            rem  = mv - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == (64'sd1 <<< 24)) begin
                q  = q / 2;
                ee = ee + 1;
            end
            if (ee >= 255) begin
                r.res = {s, 8'hFF, 23'h0};
                r.fl  = 3'b101;
            end else if (ee <= 0) begin
                r.res = {s, 31'h0};
                r.fl  = 3'b011;
            end else begin
                r.res = {s, ee[7:0], q[22:0]};
                r.fl  = {2'b00, rem != 0};
            end
        end
        return r;
    endfunction

    vec_t tbl[$];
    exp_t q_exp[$];

    initial begin
        exp_t  ex;
        logic  s, nan, inf, zero;
        int    e;
        logic [47:0] m;
        int    sel;

        tbl.push_back('{1'b0, 127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000});
        tbl.push_back('{1'b0, 127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001});
        tbl.push_back('{1'b0, 127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001});
        tbl.push_back('{1'b0, 127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001});
        tbl.push_back('{1'b0, 254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101});
        tbl.push_back('{1'b1, 0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b011});
        tbl.push_back('{1'b1, 127, 48'h9000_0000_0000, 1'b1, 1'b1, 1'b0, 32'h7FC0_0000, 3'b000});
        tbl.push_back('{1'b1, 127, 48'h4000_0040_0000, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 3'b000});
        tbl.push_back('{1'b1, 254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 3'b000});
        tbl.push_back('{1'b0, 0,   48'h4000_0000_0000, 1'b0, 1'b1, 1'b1, 32'h7F80_0000, 3'b000});
        tbl.push_back('{1'b0, 1,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b000});
        tbl.push_back('{1'b0, 254, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 3'b000});
        tbl.push_back('{1'b0, 254, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101});
        tbl.push_back('{1'b0, 0,   48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b000});
        tbl.push_back('{1'b0, -5,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b011});
        tbl.push_back('{1'b0, 127, 48'h4000_0060_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 3'b001});
        tbl.push_back('{1'b0, 127, 48'h8000_0180_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0002, 3'b001});

        // Reset state, checked while reset is held.
        #2;
        chk("reset outputs", {valid_out, overflow, underflow, inexact, result},
            {4'b0000, 32'h0});
        tick();
        arst = 1'b0;
        tick();

        // Directed vectors: one valid per entry, valid must appear after exactly two edges.
        foreach (tbl[i]) begin
            set_in(1'b1, tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].nan, tbl[i].inf, tbl[i].zero);
            tick();
            set_in(1'b0, 1'b0, 0, 48'h0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d latency1", i), {63'h0, valid_out}, 64'h0);
            tick();
            chk($sformatf("tbl%0d result", i), {32'h0, result}, {32'h0, tbl[i].res});
            chk($sformatf("tbl%0d flags", i), {60'h0, valid_out, overflow, underflow, inexact},
                {60'h0, 1'b1, tbl[i].fl});
        end
        tick();

        // Stall: two valids in flight, en low for 3 cycles, outputs frozen and order kept.
        set_in(1'b1, 1'b0, 127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stall A", {31'h0, valid_out, result}, {31'h0, 1'b1, 32'h4010_0000});
        en = 1'b0;
        set_in(1'b1, 1'b1, 3, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall frozen%0d", k), {27'h0, valid_out, overflow, underflow,
                inexact, result}, {27'h0, 4'b1000, 32'h4010_0000});
        end
        en = 1'b1;
        set_in(1'b0, 1'b0, 0, 48'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stall B", {27'h0, valid_out, overflow, underflow, inexact, result},
            {27'h0, 4'b1001, 32'h3F80_0002});
        tick();
        chk("stall no extra", {63'h0, valid_out}, 64'h0);

        // Asynchronous reset with valids in flight.
        set_in(1'b1, 1'b0, 254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("pre-reset", {27'h0, valid_out, overflow, underflow, inexact, result},
            {27'h0, 4'b1101, 32'h7F80_0000});
        #2;
        arst = 1'b1;
        #1;
        chk("async reset", {27'h0, valid_out, overflow, underflow, inexact, result}, 64'h0);
        set_in(1'b0, 1'b0, 0, 48'h0, 1'b0, 1'b0, 1'b0);
        tick();
        arst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("post-reset%0d", k), {63'h0, valid_out}, 64'h0);
        end

        // Randomized traffic with random stalls against the reference model.
        for (int n = 0; n < 600; n++) begin
            en  = ($urandom_range(0, 4) != 0);
            s   = $urandom_range(0, 1);
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                case ($urandom_range(0, 6))
                    0: e = -1;
                    1: e = 0;
                    2: e = 1;
                    3: e = 2;
                    4: e = 253;
                    5: e = 254;
                    default: e = 255;
                endcase
            end else begin
                e = int'($urandom_range(0, 400)) - 100;
            end
            m = {$urandom(), $urandom()};
            if (m[47] == 1'b0) m[46] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                m[23:0] = 24'h0;
                if ($urandom_range(0, 1) == 1) m[23] = 1'b1;
                else m[22] = 1'b1;
            end
            nan  = ($urandom_range(0, 15) == 0);
            inf  = ($urandom_range(0, 15) == 0);
            zero = ($urandom_range(0, 15) == 0);
            set_in($urandom_range(0, 3) != 0, s, e, m, nan, inf, zero);
            if (en && valid_in) q_exp.push_back(model(s, e, m, nan, inf, zero));
            tick();
            if (en && valid_out) begin
                if (q_exp.size() == 0) begin
                    chk("rand unexpected valid", {63'h0, valid_out}, 64'h0);
                end else begin
                    ex = q_exp.pop_front();
                    chk("rand word", {29'h0, overflow, underflow, inexact, result},
                        {29'h0, ex.fl, ex.res});
                end
            end
        end
        en = 1'b1;
        set_in(1'b0, 1'b0, 0, 48'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (valid_out) begin
                if (q_exp.size() == 0) begin
                    chk("drain unexpected valid", {63'h0, valid_out}, 64'h0);
                end else begin
                    ex = q_exp.pop_front();
                    chk("drain word", {29'h0, overflow, underflow, inexact, result},
                        {29'h0, ex.fl, ex.res});
                end
            end
        end
        chk("rand all delivered", 64'(q_exp.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
